// File: rtl/sdram_load_writer.sv
// Byte-stream to 16-bit byte-enable write client for one SDRAM controller channel.
// Define SDRAM_LOAD_WRITER_PACK_EN to merge adjacent even/odd byte pairs into one word write.
module sdram_load_writer #(
    parameter int FIFO_AW = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [26:0] in_addr,
    input  logic [7:0]  in_data,
    input  logic        flush,
    output logic [25:0] ch_addr,
    output logic [15:0] ch_din,
    output logic [1:0]  ch_be,
    output logic        ch_req,
    output logic        ch_rnw,
    input  logic        ch_ready,
    output logic        busy,
    output logic        err,
    output logic [15:0] wr_count
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int EW    = 44;
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   CNT_ONE    = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   CNT_FULL   = (FIFO_AW + 1)'(DEPTH);
    localparam logic [9:0]         TIMER_LAST = 10'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    logic [EW-1:0]      mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_AW:0]   count_reg;
    logic               fifo_full, fifo_empty;
    logic               accept, push, pop, pend_any;
    logic [EW-1:0]      push_entry, head;
    state_t             state_reg;
    logic [9:0]         timer_reg;

    // Entry layout {word addr, data, be}; a lone byte sits in its own lane, other lane zero.
    function automatic logic [EW-1:0] single_entry(input logic [26:0] a, input logic [7:0] d);
        return {a[26:1], (a[0] ? {d, 8'h00} : {8'h00, d}), (a[0] ? 2'b10 : 2'b01)};
    endfunction

    assign fifo_full  = (count_reg == CNT_FULL);
    assign fifo_empty = (count_reg == '0);
    assign in_ready   = !flush && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign pop        = (state_reg == REQ) && ch_ready;
    assign ch_rnw     = 1'b0;
    assign busy       = pend_any || !fifo_empty || (state_reg != IDLE);

`ifdef SDRAM_LOAD_WRITER_PACK_EN
    logic        pend_v_reg;
    logic [26:0] pend_addr_reg;
    logic [7:0]  pend_data_reg;
    logic        merge, flush_push;

    assign merge      = pend_v_reg && !pend_addr_reg[0] && (in_addr == pend_addr_reg + 27'd1);
    // A flush waits for FIFO space rather than dropping the held byte.
    assign flush_push = flush && pend_v_reg && !fifo_full;
    assign pend_any   = pend_v_reg;

    always_comb begin
        push       = 1'b0;
        push_entry = single_entry(pend_addr_reg, pend_data_reg);
        if (accept && merge) begin
            push       = 1'b1;
            push_entry = {pend_addr_reg[26:1], in_data, pend_data_reg, 2'b11};
        end else if ((accept && pend_v_reg) || flush_push) begin
            push = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_v_reg    <= 1'b0;
            pend_addr_reg <= '0;
            pend_data_reg <= '0;
        end else if (accept) begin
            if (merge) begin
                pend_v_reg <= 1'b0;
            end else begin
                pend_v_reg    <= 1'b1;
                pend_addr_reg <= in_addr;
                pend_data_reg <= in_data;
            end
        end else if (flush_push) begin
            pend_v_reg <= 1'b0;
        end
    end
`else
    assign pend_any   = 1'b0;
    assign push       = accept;
    assign push_entry = single_entry(in_addr, in_data);
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    // Head is read straight from the array so a request can issue the edge after a push.
    assign head = mem[rd_ptr_reg];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            ch_req    <= 1'b0;
            ch_addr   <= '0;
            ch_din    <= '0;
            ch_be     <= '0;
            timer_reg <= '0;
            err       <= 1'b0;
            wr_count  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        {ch_addr, ch_din, ch_be} <= head;
                        ch_req    <= 1'b1;
                        timer_reg <= '0;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (ch_ready) begin
                        wr_count  <= wr_count + 16'd1;
                        ch_req    <= 1'b0;
                        state_reg <= GAP;
                    end else if (timer_reg == TIMER_LAST) begin
                        // Entry stays at the FIFO head and is re-requested after the gap.
                        err       <= 1'b1;
                        ch_req    <= 1'b0;
                        state_reg <= GAP;
                    end else begin
                        timer_reg <= timer_reg + 10'd1;
                    end
                end
                GAP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_load_writer.sv
// Scoreboard bench for sdram_load_writer: reference packer model feeds an expected-write queue.
`timescale 1ns/1ps
module tb_sdram_load_writer;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, ch_ready;
    logic        in_ready, ch_req, ch_rnw, busy, err;
    logic [26:0] in_addr;
    logic [7:0]  in_data;
    logic [25:0] ch_addr;
    logic [15:0] ch_din, wr_count;
    logic [1:0]  ch_be;

    sdram_load_writer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .flush(flush),
        .ch_addr(ch_addr), .ch_din(ch_din), .ch_be(ch_be), .ch_req(ch_req),
        .ch_rnw(ch_rnw), .ch_ready(ch_ready), .busy(busy), .err(err), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [25:0] addr;
        logic [15:0] din;
        logic [1:0]  be;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0, passes = 0;
    int          pushed = 0, done_cnt = 0;
    int          ready_delay = 4;
    bit          never_ready = 0;
    bit          drop_seen = 0;
    int          drop_occ = -1;
    bit          pv = 0;
    logic [26:0] pa;
    logic [7:0]  pd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push_exp(input logic [25:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_t e;
        e.addr = a; e.din = d; e.be = be;
        exp_q.push_back(e);
        pushed++;
    endtask

    // A lone byte is written to word addr/2 in lane (addr mod 2).
    task automatic push_byte(input logic [26:0] a, input logic [7:0] d);
        if (a % 2 == 1) push_exp(26'(a / 2), {d, 8'h00}, 2'b10);
        else            push_exp(26'(a / 2), {8'h00, d}, 2'b01);
    endtask

    task automatic model_accept(input logic [26:0] a, input logic [7:0] d);
`ifdef SDRAM_LOAD_WRITER_PACK_EN
        if (pv && (pa % 2 == 0) && (a == pa + 27'd1)) begin
            push_exp(26'(pa / 2), {d, pd}, 2'b11);
            pv = 0;
        end else begin
            if (pv) push_byte(pa, pd);
            pv = 1; pa = a; pd = d;
        end
`else
        push_byte(a, d);
`endif
    endtask

    task automatic model_flush();
`ifdef SDRAM_LOAD_WRITER_PACK_EN
        if (pv) push_byte(pa, pd);
        pv = 0;
`endif
    endtask

    task automatic send(input logic [26:0] a, input logic [7:0] d);
        bit ok;
        in_valid = 1'b1; in_addr = a; in_data = d;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            if (ok) begin
                model_accept(a, d);
                $display("byte  addr=0x%07h data=0x%02h accepted", a, d);
                in_valid = 1'b0;
                return;
            end
        end
        check("in_ready wait", in_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        model_flush();
        flush = 1'b0;
        $display("flush issued");
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        check({name, " drained"}, 64'(exp_q.size()), 0);
        check({name, " idle"}, busy, 0);
        @(posedge clk); #1;
    endtask

    // Controller model: pulse ch_ready ready_delay cycles into each request.
    initial begin : responder
        int hi;
        hi = 0;
        ch_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (ch_req && !never_ready && !reset) begin
                hi++;
                if (hi >= ready_delay) begin
                    @(posedge clk); #1 ch_ready = 1'b1;
                    @(posedge clk); #1 ch_ready = 1'b0;
                    done_cnt++;
                    hi = 0;
                    @(negedge clk);
                    check("wr_count", wr_count, 64'(done_cnt[15:0]));
                end
            end else begin
                hi = 0;
            end
        end
    end

    always @(negedge clk) begin : monitor
        wr_t e;
        if (!reset) begin
            check("in_ready vs occupancy", in_ready, 64'(!flush && (pushed - done_cnt) < 8));
            if (!flush && !in_ready && !drop_seen) begin
                drop_seen = 1;
                drop_occ  = pushed - done_cnt;
            end
            if (ch_ready && ch_req) begin
                if (exp_q.size() == 0) begin
                    check("unexpected write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("write addr=0x%07h din=0x%04h be=%b (exp 0x%07h 0x%04h %b)",
                             ch_addr, ch_din, ch_be, e.addr, e.din, e.be);
                    check("ch_addr", ch_addr, e.addr);
                    check("ch_din", ch_din, e.din);
                    check("ch_be", ch_be, e.be);
                    check("ch_rnw", ch_rnw, 0);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, " ch_req"}, ch_req, 0);
        check({tag, " ch_addr"}, ch_addr, 0);
        check({tag, " ch_din"}, ch_din, 0);
        check({tag, " ch_be"}, ch_be, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " err"}, err, 0);
        check({tag, " wr_count"}, wr_count, 0);
        check({tag, " in_ready"}, in_ready, 1);
    endtask

    initial begin : stimulus
        logic [26:0] a;
        int hi;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; in_addr = '0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        ready_delay = 4;
        send(27'h100, 8'h11); send(27'h101, 8'h22);
        do_flush();
        drain("pair");

        send(27'h201, 8'h33);
        do_flush();
        drain("odd");

        send(27'h010, 8'hA5); send(27'h012, 8'h5A);
        do_flush();
        drain("nonadj");

        ready_delay = 8;
        drop_seen = 0;
        for (int i = 0; i < 20; i++) begin
            send(27'h1000 + 27'(2 * i), 8'(2 * i));
            send(27'h1001 + 27'(2 * i), 8'(2 * i + 1));
        end
        drain("stream");
        check("in_ready dropped", drop_seen, 1);
        check("occupancy at drop", 64'(drop_occ), 8);

        for (int r = 0; r < 3; r++) begin
            ready_delay = $urandom_range(1, 6);
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    a = 27'($urandom) & ~27'd1;
                    send(a, 8'($urandom));
                    send(a + 27'd1, 8'($urandom));
                end else begin
                    send(27'($urandom), 8'($urandom));
                end
                if ($urandom_range(0, 9) == 0) do_flush();
            end
            do_flush();
            drain("random");
        end
        check("err before timeout", err, 0);

        never_ready = 1;
        send(27'h300, 8'h44); send(27'h301, 8'h55);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (ch_req) break;
        end
        check("timeout req rose", ch_req, 1);
        hi = 1;
        for (int t = 0; t < 1500; t++) begin
            @(negedge clk);
            if (ch_req) hi++;
            else break;
        end
        $display("timeout req high for %0d cycles", hi);
        check("timeout req width", 64'(hi), 1023);
        check("err set", err, 1);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (ch_req) break;
        end
        check("retry req", ch_req, 1);
        if (exp_q.size() > 0) begin
            check("retry ch_addr", ch_addr, exp_q[0].addr);
            check("retry ch_din", ch_din, exp_q[0].din);
            check("retry ch_be", ch_be, exp_q[0].be);
        end else begin
            check("retry entry queued", 64'(exp_q.size()), 1);
        end

        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("mid-REQ reset");
        exp_q.delete();
        pushed = 0; done_cnt = 0; pv = 0;
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_reset_outputs("after reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
